mt_regfile_bram: RTL and testbench
==================================

// Module: mt_regfile_bram
// PURPOSE
//  Parametrised multithreaded register file for the barrel-processor core, mapped to BRAM.
//  Holds NUM_THREADS x REGFILE_SIZE words of DWIDTH bits; entry address = {thread, reg}.
//  Provides NUM_RD_PORTS synchronous read ports and one write port; BRAM is replicated per read port.
//  Adds hardware zero-initialisation after reset, per-thread context clear, write-first bypass and x0 hardwiring.
// PARAMETERS
//  DWIDTH        32  data word width
//  NUM_THREADS   16  hardware thread contexts (power of 2, >=2)
//  REGFILE_SIZE  32  architectural registers per thread (power of 2)
//  NUM_RD_PORTS  2   read ports (1..3)
//  BYPASS_EN     1   1: same-cycle write forwarded to read output; 0: read returns old data
//  derived: TW = clog2(NUM_THREADS), RW = clog2(REGFILE_SIZE), RF_SIZE = NUM_THREADS*REGFILE_SIZE
// PORTS
//  clk            in   1                  single clock, all logic rising-edge
//  reset_n        in   1                  asynchronous, active-low reset
//  i_rd_en        in   1                  read strobe, all read ports
//  i_rd_thread    in   TW                 thread for reads
//  i_rs_addr      in   NUM_RD_PORTS x RW  per-port source register index
//  o_rs_data      out  NUM_RD_PORTS x DWIDTH  registered read data
//  i_we           in   1                  write enable
//  i_wr_thread    in   TW                 thread for write
//  i_wr_addr      in   RW                 destination register index
//  i_wr_data      in   DWIDTH             write data
//  i_clr_req      in   1                  request clear of one thread context (single-cycle pulse)
//  i_clr_thread   in   TW                 thread to clear
//  o_busy         out  1                  init or clear sweep in progress
//  o_clr_done     out  1                  one-cycle pulse when clear sweep finishes
//  o_wr_drop      out  1                  one-cycle pulse: user write discarded because busy
// BEHAVIOUR
//  Reset (reset_n=0): o_rs_data=0, o_busy=1, o_clr_done=0, o_wr_drop=0, FSM=INIT, sweep ptr=0.
//  FSM states: INIT, IDLE, CLEAR.
//   INIT: writes 0 to entry ptr each cycle, ptr 0..RF_SIZE-1; leaving after RF_SIZE cycles -> IDLE.
//   IDLE: o_busy=0; i_clr_req=1 latches i_clr_thread, ptr=0 -> CLEAR next cycle.
//   CLEAR: writes 0 to {clr_thread, ptr}, ptr 0..REGFILE_SIZE-1; after last entry -> IDLE, o_clr_done=1
//          in the cycle FSM returns to IDLE. o_busy=1 throughout CLEAR.
//  i_clr_req while o_busy=1 is ignored (no queueing); caller waits for o_busy=0.
//  Write port: sweep owns it while busy; user write with i_we=1 during busy is dropped, o_wr_drop=1 next cycle.
//  Writes to reg 0 are discarded (never reach BRAM, no drop pulse). Write commits at rising edge.
//  Reads: latency 1; o_rs_data[p] updates the cycle after i_rd_en=1; holds value while i_rd_en=0.
//   rs_addr=0 -> 0. INIT: all reads return 0. CLEAR: reads of clr_thread return 0, other threads normal.
//   BYPASS_EN=1 and accepted write {wr_thread,wr_addr}=={rd_thread,rs_addr[p]} same cycle -> i_wr_data.
//   BYPASS_EN=0 -> old BRAM contents (read-first).
//  Reset asserted mid-CLEAR or mid-INIT aborts the sweep; full INIT sweep restarts from ptr=0.
//  Ptr wrap: counters sized for full range; no wrap beyond last entry (terminal compare, not overflow).
//  No combinational path from inputs to outputs.
// TESTING
//  T1 reset release, NUM_THREADS=16, REGFILE_SIZE=32 -> o_busy high exactly 512 cycles, then all reads 0.
//  T2 write t3/x5=0xDEADBEEF, next cycle read t3 rs0=x5, rs1=x0 -> o_rs_data = {0xDEADBEEF, 0} one cycle later.
//  T3 same-cycle write t7/x9=0x1234 and read t7/x9: BYPASS_EN=1 -> 0x1234; BYPASS_EN=0 -> prior value 0.
//  T4 fill t2 and t4 x1..x31 with 0xA5A5_00NN, clr_req t2 -> busy 32 cycles, clr_done pulse; t2 all 0, t4 intact.
//  T5 i_we=1 to t1/x1 during CLEAR of t2 -> o_wr_drop=1, t1/x1 unchanged; write to x0 -> no drop, reads 0.
//  T6 assert reset_n=0 at CLEAR cycle 10, release -> full 512-cycle INIT, all entries 0, o_clr_done never pulses.

Source files
------------

// File: rtl/mt_regfile_bram_if.sv
// Bundles the register-file read, write and clear signals between the core and mt_regfile_bram.
// The interface is pure wiring and adds no latency.
// There is no backpressure: callers watch o_busy, o_wr_drop and o_clr_done.
interface mt_regfile_bram_if #(
    parameter int DWIDTH       = 32,
    parameter int NUM_THREADS  = 16,
    parameter int REGFILE_SIZE = 32,
    parameter int NUM_RD_PORTS = 2
);
    localparam int TW = $clog2(NUM_THREADS);
    localparam int RW = $clog2(REGFILE_SIZE);

    // read side
    logic                                     i_rd_en;
    logic [TW-1:0]                            i_rd_thread;
    logic [NUM_RD_PORTS-1:0][RW-1:0]          i_rs_addr;
    logic [NUM_RD_PORTS-1:0][DWIDTH-1:0]      o_rs_data;
    // write side
    logic                                     i_we;
    logic [TW-1:0]                            i_wr_thread;
    logic [RW-1:0]                            i_wr_addr;
    logic [DWIDTH-1:0]                        i_wr_data;
    // context clear and status
    logic                                     i_clr_req;
    logic [TW-1:0]                            i_clr_thread;
    logic                                     o_busy;
    logic                                     o_clr_done;
    logic                                     o_wr_drop;

    modport master (
        output i_rd_en, i_rd_thread, i_rs_addr,
        output i_we, i_wr_thread, i_wr_addr, i_wr_data,
        output i_clr_req, i_clr_thread,
        input  o_rs_data, o_busy, o_clr_done, o_wr_drop
    );

    modport slave (
        input  i_rd_en, i_rd_thread, i_rs_addr,
        input  i_we, i_wr_thread, i_wr_addr, i_wr_data,
        input  i_clr_req, i_clr_thread,
        output o_rs_data, o_busy, o_clr_done, o_wr_drop
    );
endinterface

// File: rtl/mt_regfile_bram.sv
// Multithreaded BRAM register file: {thread,reg} addressing, replicated per read port, with zero-init, context clear, bypass and x0 hardwiring.
// Reads have 1-cycle latency, and the output holds while i_rd_en=0. Status pulses are registered 1 cycle after their cause.
// There is no stall: while the init/clear sweep owns the write port, user writes are dropped (o_wr_drop) and clear requests are ignored.
module mt_regfile_bram #(
    parameter int DWIDTH       = 32,
    parameter int NUM_THREADS  = 16,
    parameter int REGFILE_SIZE = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int BYPASS_EN    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    mt_regfile_bram_if.slave  bus
);
    localparam int TW      = $clog2(NUM_THREADS);
    localparam int RW      = $clog2(REGFILE_SIZE);
    localparam int AW      = TW + RW;
    localparam int RF_SIZE = NUM_THREADS * REGFILE_SIZE;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CLEAR} state_t;

    state_t                              state_q, state_d;
    logic [AW-1:0]                       ptr_q, ptr_d;
    logic [TW-1:0]                       clr_thread_q, clr_thread_d;
    logic                                clr_done_q, clr_done_d;
    logic                                wr_drop_q, wr_drop_d;
    logic [NUM_RD_PORTS-1:0][DWIDTH-1:0] rs_data_q, rs_data_d;

    logic                                busy;
    logic                                usr_wr_vld;
    logic                                usr_wr_acc;
    logic                                rd_zero;
    logic                                mem_we;
    logic [AW-1:0]                       mem_waddr;
    logic [DWIDTH-1:0]                   mem_wdata;

    // one identical copy per read port, so each copy needs only one read and one write port
    logic [DWIDTH-1:0]                   mem_q [NUM_RD_PORTS][RF_SIZE];

    // FSM state, sweep pointer and registered status pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_INIT;
            ptr_q        <= '0;
            clr_thread_q <= '0;
            clr_done_q   <= 1'b0;
            wr_drop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            clr_thread_q <= clr_thread_d;
            clr_done_q   <= clr_done_d;
            wr_drop_q    <= wr_drop_d;
        end
    end

    // sweep sequencing; the exit is a terminal compare on the pointer, never a counter overflow
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        clr_thread_d = clr_thread_q;
        clr_done_d   = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                if (ptr_q == AW'(RF_SIZE - 1)) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            ST_IDLE: begin
                if (bus.i_clr_req) begin
                    state_d      = ST_CLEAR;
                    clr_thread_d = bus.i_clr_thread;
                    ptr_d        = '0;
                end
            end
            ST_CLEAR: begin
                if (ptr_q[RW-1:0] == RW'(REGFILE_SIZE - 1)) begin
                    state_d    = ST_IDLE;
                    ptr_d      = '0;
                    clr_done_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    // write-port ownership: the sweep writes zeros while busy, otherwise the user write (never to x0)
    always_comb begin
        busy       = (state_q != ST_IDLE);
        usr_wr_vld = bus.i_we && (bus.i_wr_addr != '0);
        usr_wr_acc = usr_wr_vld && !busy;
        wr_drop_d  = usr_wr_vld && busy;
        rd_zero    = (state_q == ST_INIT) ||
                     ((state_q == ST_CLEAR) && (bus.i_rd_thread == clr_thread_q));
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        unique case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = {clr_thread_q, ptr_q[RW-1:0]};
            end
            default: begin
                mem_we    = usr_wr_acc;
                mem_waddr = {bus.i_wr_thread, bus.i_wr_addr};
                mem_wdata = bus.i_wr_data;
            end
        endcase
    end

    // every replica takes the same write so all ports see identical contents
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                mem_q[p][mem_waddr] <= mem_wdata;
            end
        end
    end

    // read data selection: forced zero (x0, init, context under clear), then bypass, then the array (read-first)
    always_comb begin
        rs_data_d = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (rd_zero || (bus.i_rs_addr[p] == '0)) begin
                rs_data_d[p] = '0;
            end else if ((BYPASS_EN != 0) && usr_wr_acc &&
                         (bus.i_wr_thread == bus.i_rd_thread) &&
                         (bus.i_wr_addr == bus.i_rs_addr[p])) begin
                rs_data_d[p] = bus.i_wr_data;
            end else begin
                rs_data_d[p] = mem_q[p][{bus.i_rd_thread, bus.i_rs_addr[p]}];
            end
        end
    end

    // registered read output, held while no read is requested
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rs_data_q <= '0;
        end else if (bus.i_rd_en) begin
            rs_data_q <= rs_data_d;
        end
    end

    assign bus.o_rs_data  = rs_data_q;
    assign bus.o_busy     = busy;
    assign bus.o_clr_done = clr_done_q;
    assign bus.o_wr_drop  = wr_drop_q;
endmodule

// File: tb/tb_mt_regfile_bram.sv
// Directed bench for mt_regfile_bram: one instance with bypass and one without, both checked against a contents/countdown model.
// The model's expectations appear 1 cycle after the inputs that cause them.
// The bench drives no backpressure; it waits on o_busy with bounded loops.
module tb_mt_regfile_bram;
    localparam int DW = 32;
    localparam int NT = 16;
    localparam int RS = 32;
    localparam int NP = 2;
    localparam int TW = $clog2(NT);
    localparam int RW = $clog2(RS);

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    bit   checking = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mt_regfile_bram_if #(.DWIDTH(DW), .NUM_THREADS(NT), .REGFILE_SIZE(RS), .NUM_RD_PORTS(NP)) bus ();
    mt_regfile_bram_if #(.DWIDTH(DW), .NUM_THREADS(NT), .REGFILE_SIZE(RS), .NUM_RD_PORTS(NP)) bus_nb ();

    assign bus_nb.i_rd_en      = bus.i_rd_en;
    assign bus_nb.i_rd_thread  = bus.i_rd_thread;
    assign bus_nb.i_rs_addr    = bus.i_rs_addr;
    assign bus_nb.i_we         = bus.i_we;
    assign bus_nb.i_wr_thread  = bus.i_wr_thread;
    assign bus_nb.i_wr_addr    = bus.i_wr_addr;
    assign bus_nb.i_wr_data    = bus.i_wr_data;
    assign bus_nb.i_clr_req    = bus.i_clr_req;
    assign bus_nb.i_clr_thread = bus.i_clr_thread;

    mt_regfile_bram #(.DWIDTH(DW), .NUM_THREADS(NT), .REGFILE_SIZE(RS), .NUM_RD_PORTS(NP), .BYPASS_EN(1)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));
    mt_regfile_bram #(.DWIDTH(DW), .NUM_THREADS(NT), .REGFILE_SIZE(RS), .NUM_RD_PORTS(NP), .BYPASS_EN(0)) dut_nb (
        .clk(clk), .reset_n(reset_n), .bus(bus_nb));

    // ---------------- model: architectural contents plus busy countdowns ----------------
    logic [DW-1:0] mdl [NT][RS];
    logic [DW-1:0] exp_rs [NP];
    logic [DW-1:0] exp_rs_nb [NP];
    bit exp_busy, exp_done, exp_drop;
    int init_left, clr_left, clr_thr;

    initial forever begin
        bit busy_now, wr_acc;
        int t, a, wt, wa;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            for (int i = 0; i < NT; i++) for (int j = 0; j < RS; j++) mdl[i][j] = '0;
            for (int p = 0; p < NP; p++) begin exp_rs[p] = '0; exp_rs_nb[p] = '0; end
            init_left = NT * RS;
            clr_left  = 0;
            exp_busy  = 1'b1;
            exp_done  = 1'b0;
            exp_drop  = 1'b0;
        end else begin
            busy_now = (init_left > 0) || (clr_left > 0);
            wt = int'(bus.i_wr_thread);
            wa = int'(bus.i_wr_addr);
            wr_acc = bus.i_we && !busy_now && (wa != 0);
            if (bus.i_rd_en) begin
                t = int'(bus.i_rd_thread);
                for (int p = 0; p < NP; p++) begin
                    a = int'(bus.i_rs_addr[p]);
                    if (a == 0 || init_left > 0 || (clr_left > 0 && t == clr_thr)) begin
                        exp_rs[p] = '0;
                        exp_rs_nb[p] = '0;
                    end else begin
                        exp_rs_nb[p] = mdl[t][a];
                        exp_rs[p] = (wr_acc && wt == t && wa == a) ? bus.i_wr_data : mdl[t][a];
                    end
                end
            end
            exp_drop = bus.i_we && busy_now && (wa != 0);
            if (wr_acc) mdl[wt][wa] = bus.i_wr_data;
            exp_done = 1'b0;
            if (init_left > 0) begin
                init_left--;
            end else if (clr_left > 0) begin
                clr_left--;
                if (clr_left == 0) exp_done = 1'b1;
            end else if (bus.i_clr_req) begin
                clr_left = RS;
                clr_thr  = int'(bus.i_clr_thread);
                for (int j = 0; j < RS; j++) mdl[clr_thr][j] = '0;
            end
            exp_busy = (init_left > 0) || (clr_left > 0);
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // per-cycle compare of both instances against the model
    initial forever begin
        @(negedge clk);
        if (checking) begin
            check("busy",       DW'(bus.o_busy),        DW'(exp_busy));
            check("clr_done",   DW'(bus.o_clr_done),    DW'(exp_done));
            check("wr_drop",    DW'(bus.o_wr_drop),     DW'(exp_drop));
            check("nb_busy",    DW'(bus_nb.o_busy),     DW'(exp_busy));
            check("nb_clr_done", DW'(bus_nb.o_clr_done), DW'(exp_done));
            for (int p = 0; p < NP; p++) begin
                check("rs_data",    bus.o_rs_data[p],    exp_rs[p]);
                check("nb_rs_data", bus_nb.o_rs_data[p], exp_rs_nb[p]);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [TW-1:0] t, input logic [RW-1:0] r, input logic [DW-1:0] d);
        bus.i_we = 1'b1; bus.i_wr_thread = t; bus.i_wr_addr = r; bus.i_wr_data = d;
        tick();
        bus.i_we = 1'b0;
    endtask

    task automatic rd(input logic [TW-1:0] t, input logic [RW-1:0] a0, input logic [RW-1:0] a1);
        bus.i_rd_en = 1'b1; bus.i_rd_thread = t; bus.i_rs_addr[0] = a0; bus.i_rs_addr[1] = a1;
        tick();
        bus.i_rd_en = 1'b0;
    endtask

    task automatic clr(input logic [TW-1:0] t);
        bus.i_clr_req = 1'b1; bus.i_clr_thread = t;
        tick();
        bus.i_clr_req = 1'b0;
    endtask

    // counts busy cycles (bounded) and clear-done pulses until busy drops
    task automatic count_busy(input int limit, output int cnt, output int dn);
        cnt = 0;
        dn  = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.o_clr_done) dn++;
            if (!bus.o_busy) break;
            cnt++;
        end
    endtask

    initial begin
        int cnt, dn;
        bus.i_rd_en = 1'b0; bus.i_rd_thread = '0; bus.i_rs_addr = '0;
        bus.i_we = 1'b0; bus.i_wr_thread = '0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
        bus.i_clr_req = 1'b0; bus.i_clr_thread = '0;
        repeat (3) @(posedge clk);
        checking = 1'b1;
        #1;
        // reset state is held before release
        @(negedge clk);
        check("rst_busy", DW'(bus.o_busy), 32'd1);
        check("rst_rs0", bus.o_rs_data[0], 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // T1: init sweep spans the whole array
        count_busy(2000, cnt, dn);
        check("t1_busy_cycles", DW'(cnt), 32'd512);
        rd(4'd5, 5'd7, 5'd31);
        @(negedge clk);
        check("t1_rd0", bus.o_rs_data[0], 32'd0);
        check("t1_rd1", bus.o_rs_data[1], 32'd0);

        // T2: write then read next cycle, with rs1 on x0
        wr(4'd3, 5'd5, 32'hDEADBEEF);
        rd(4'd3, 5'd5, 5'd0);
        @(negedge clk);
        check("t2_rs0", bus.o_rs_data[0], 32'hDEADBEEF);
        check("t2_rs1", bus.o_rs_data[1], 32'd0);
        tick();
        @(negedge clk);
        check("t2_hold", bus.o_rs_data[0], 32'hDEADBEEF);

        // T3: same-cycle write and read of one entry
        bus.i_we = 1'b1; bus.i_wr_thread = 4'd7; bus.i_wr_addr = 5'd9; bus.i_wr_data = 32'h1234;
        bus.i_rd_en = 1'b1; bus.i_rd_thread = 4'd7; bus.i_rs_addr[0] = 5'd9; bus.i_rs_addr[1] = 5'd9;
        tick();
        bus.i_we = 1'b0; bus.i_rd_en = 1'b0;
        @(negedge clk);
        check("t3_bypass", bus.o_rs_data[0], 32'h1234);
        check("t3_nobypass", bus_nb.o_rs_data[0], 32'd0);
        rd(4'd7, 5'd9, 5'd0);
        @(negedge clk);
        check("t3_nb_after", bus_nb.o_rs_data[0], 32'h1234);

        // T4: fill two contexts, clear one
        for (int r = 1; r < RS; r++) begin
            wr(4'd2, RW'(r), 32'hA5A5_0000 | DW'(r));
            wr(4'd4, RW'(r), 32'hA5A5_0000 | DW'(r));
        end
        clr(4'd2);
        count_busy(200, cnt, dn);
        check("t4_busy_cycles", DW'(cnt), 32'd32);
        check("t4_done_pulses", DW'(dn), 32'd1);
        for (int r = 0; r < RS; r++) begin
            rd(4'd2, RW'(r), RW'(RS - 1 - r));
            rd(4'd4, RW'(r), RW'(RS - 1 - r));
        end
        rd(4'd4, 5'd31, 5'd5);
        @(negedge clk);
        check("t4_t4_x31", bus.o_rs_data[0], 32'hA5A5_001F);
        check("t4_t4_x5",  bus.o_rs_data[1], 32'hA5A5_0005);
        rd(4'd2, 5'd31, 5'd5);
        @(negedge clk);
        check("t4_t2_x31", bus.o_rs_data[0], 32'd0);

        // T5: writes during a clear are dropped, x0 writes silently ignored
        wr(4'd1, 5'd1, 32'h1111_1111);
        clr(4'd2);
        wr(4'd1, 5'd1, 32'h0BAD_0BAD);
        @(negedge clk);
        check("t5_drop", DW'(bus.o_wr_drop), 32'd1);
        wr(4'd1, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        check("t5_x0_nodrop", DW'(bus.o_wr_drop), 32'd0);
        rd(4'd2, 5'd3, 5'd4);
        rd(4'd1, 5'd1, 5'd0);
        @(negedge clk);
        check("t5_rd_other", bus.o_rs_data[0], 32'h1111_1111);
        count_busy(100, cnt, dn);
        check("t5_idle", DW'(bus.o_busy), 32'd0);
        rd(4'd1, 5'd1, 5'd0);
        @(negedge clk);
        check("t5_t1_x1", bus.o_rs_data[0], 32'h1111_1111);
        check("t5_t1_x0", bus.o_rs_data[1], 32'd0);

        // T6: reset in the middle of a clear restarts the full init
        clr(4'd4);
        repeat (10) tick();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        count_busy(2000, cnt, dn);
        check("t6_busy_cycles", DW'(cnt), 32'd512);
        check("t6_no_done", DW'(dn), 32'd0);
        rd(4'd4, 5'd3, 5'd31);
        @(negedge clk);
        check("t6_t4_x3", bus.o_rs_data[0], 32'd0);
        rd(4'd1, 5'd1, 5'd0);
        @(negedge clk);
        check("t6_t1_x1", bus.o_rs_data[0], 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
